// File: rtl/stage_1_if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction SRAM and
// hands {inst, pc} to ID, holding the fetched word steady while ID stalls.
module stage_1_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        allow_2,
  output logic        valid_1,
  output logic [63:0] stage_1_to_2,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;

  logic [31:0] pc_cur;
  logic [31:0] nextpc;
  logic [31:0] inst;
  logic        go;

  always_comb begin
    // Force the reset view even before the first edge has cleared the registers.
    pc_cur = reset ? (RESET_PC - 32'd4) : pc_q;
    nextpc = br_taken ? br_target : (pc_cur + 32'd4);
    go     = ~reset & (allow_2 | ~valid_q | br_taken);
    inst   = (~reset & inst_buf_valid_q) ? inst_buf_q : inst_sram_rdata;
  end

  always_comb begin
    pc_d             = pc_q;
    valid_d          = valid_q;
    inst_buf_d       = inst_buf_q;
    inst_buf_valid_d = inst_buf_valid_q;
    if (go) begin
      pc_d             = nextpc;
      valid_d          = 1'b1;
      inst_buf_valid_d = 1'b0;
    end else if (!inst_buf_valid_q) begin
      // First stall cycle: SRAM output is still the word for pc, capture it.
      inst_buf_d       = inst_sram_rdata;
      inst_buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q             <= RESET_PC - 32'd4;
      valid_q          <= 1'b0;
      inst_buf_q       <= 32'b0;
      inst_buf_valid_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      valid_q          <= valid_d;
      inst_buf_q       <= inst_buf_d;
      inst_buf_valid_q <= inst_buf_valid_d;
    end
  end

  assign valid_1         = valid_q & ~reset;
  assign stage_1_to_2    = {inst, pc_cur};
  assign inst_sram_en    = go;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_stage_1_if_fetch.sv
// Bench for stage_1_if_fetch: directed vector table, hand sequences for wrap and
// mid-stall reset, then random traffic against a PC/valid reference model.
module tb_stage_1_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam logic [31:0] PC_RST   = RESET_PC - 32'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        allow_2 = 1'b0;
  logic        valid_1;
  logic [63:0] stage_1_to_2;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'b0;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'b0;

  int nvec = 0;
  int nfail = 0;

  stage_1_if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .allow_2        (allow_2),
    .valid_1        (valid_1),
    .stage_1_to_2   (stage_1_to_2),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Memory image: the instruction word stored at each address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1c000008) return 32'h02800421;
    return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
  endfunction

  // Synchronous SRAM; returns junk on idle cycles so a missing hold buffer shows up.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= mem(inst_sram_addr);
    else              inst_sram_rdata <= $urandom();
  end

  // Reference model: IF holds "the instruction at pc" whenever it is valid.
  logic [31:0] m_pc = PC_RST;
  logic        m_valid = 1'b0;

  typedef struct {
    logic        rst, allow, br;
    logic [31:0] tgt;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        chk_inst;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic r, input logic a, input logic b, input logic [31:0] t);
    reset = r; allow_2 = a; br_taken = b; br_target = t;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (reset) begin
      m_pc = PC_RST; m_valid = 1'b0;
    end else if (allow_2 || !m_valid || br_taken) begin
      m_pc = br_taken ? br_target : m_pc + 32'd4;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic check_model();
    logic go;
    go = !reset && (allow_2 || !m_valid || br_taken);
    chk("en", 64'(inst_sram_en), 64'(go));
    chk("we_wdata", {28'b0, inst_sram_we, inst_sram_wdata}, 64'b0);
    if (reset) begin
      chk("rst_valid", 64'(valid_1), 64'b0);
      chk("rst_out", stage_1_to_2, {inst_sram_rdata, PC_RST});
    end else begin
      chk("addr", 64'(inst_sram_addr), 64'(br_taken ? br_target : m_pc + 32'd4));
      chk("valid", 64'(valid_1), 64'(m_valid));
      chk("pc", 64'(stage_1_to_2[31:0]), 64'(m_pc));
      if (m_valid) chk("inst", 64'(stage_1_to_2[63:32]), 64'(mem(m_pc)));
    end
  endtask

  task automatic add(input logic r, a, b, input logic [31:0] t, input logic en,
                     input logic [31:0] addr, input logic v, input logic [31:0] pc,
                     input logic ci);
    vec_t x;
    x.rst = r; x.allow = a; x.br = b; x.tgt = t; x.en = en; x.addr = addr;
    x.valid = v; x.pc = pc; x.inst = mem(pc); x.chk_inst = ci;
    vecs.push_back(x);
  endtask

  initial begin
    // Reset, streaming, 3-cycle stall, redirect, redirect out of a buffered stall,
    // back-to-back redirects.
    add(1, 1, 0, 0,            0, 32'h1c000000, 0, PC_RST,       0);
    add(1, 1, 0, 0,            0, 32'h1c000000, 0, PC_RST,       0);
    add(0, 1, 0, 0,            1, 32'h1c000000, 0, PC_RST,       0);
    add(0, 1, 0, 0,            1, 32'h1c000004, 1, 32'h1c000000, 1);
    add(0, 1, 0, 0,            1, 32'h1c000008, 1, 32'h1c000004, 1);
    add(0, 0, 0, 0,            0, 32'h1c00000c, 1, 32'h1c000008, 1);
    add(0, 0, 0, 0,            0, 32'h1c00000c, 1, 32'h1c000008, 1);
    add(0, 0, 0, 0,            0, 32'h1c00000c, 1, 32'h1c000008, 1);
    add(0, 1, 0, 0,            1, 32'h1c00000c, 1, 32'h1c000008, 1);
    add(0, 1, 1, 32'h1c000100, 1, 32'h1c000100, 1, 32'h1c00000c, 1);
    add(0, 1, 0, 0,            1, 32'h1c000104, 1, 32'h1c000100, 1);
    add(0, 0, 0, 0,            0, 32'h1c000108, 1, 32'h1c000104, 1);
    add(0, 0, 0, 0,            0, 32'h1c000108, 1, 32'h1c000104, 1);
    add(0, 0, 1, 32'h1c000200, 1, 32'h1c000200, 1, 32'h1c000104, 1);
    add(0, 0, 0, 0,            0, 32'h1c000204, 1, 32'h1c000200, 1);
    add(0, 1, 1, 32'h1c000300, 1, 32'h1c000300, 1, 32'h1c000200, 1);
    add(0, 1, 1, 32'h1c000400, 1, 32'h1c000400, 1, 32'h1c000300, 1);
    add(0, 1, 0, 0,            1, 32'h1c000404, 1, 32'h1c000400, 1);

    foreach (vecs[i]) begin
      set_in(vecs[i].rst, vecs[i].allow, vecs[i].br, vecs[i].tgt);
      @(negedge clk);
      chk($sformatf("tbl%0d_en", i), 64'(inst_sram_en), 64'(vecs[i].en));
      chk($sformatf("tbl%0d_addr", i), 64'(inst_sram_addr), 64'(vecs[i].addr));
      chk($sformatf("tbl%0d_valid", i), 64'(valid_1), 64'(vecs[i].valid));
      chk($sformatf("tbl%0d_pc", i), 64'(stage_1_to_2[31:0]), 64'(vecs[i].pc));
      if (vecs[i].chk_inst)
        chk($sformatf("tbl%0d_inst", i), 64'(stage_1_to_2[63:32]), 64'(vecs[i].inst));
      finish_cycle();
    end

    // PC wrap at the top of the address space.
    set_in(0, 1, 1, 32'hfffffffc);
    @(negedge clk);
    chk("wrap_br_addr", 64'(inst_sram_addr), 64'hfffffffc);
    finish_cycle();
    set_in(0, 1, 0, 0);
    @(negedge clk);
    chk("wrap_pc", 64'(stage_1_to_2[31:0]), 64'hfffffffc);
    chk("wrap_addr", 64'(inst_sram_addr), 64'h0);
    chk("wrap_inst", 64'(stage_1_to_2[63:32]), 64'(mem(32'hfffffffc)));
    finish_cycle();
    @(negedge clk);
    chk("wrap_pc0", 64'(stage_1_to_2[31:0]), 64'h0);
    chk("wrap_addr4", 64'(inst_sram_addr), 64'h4);
    finish_cycle();

    // Reset in the middle of a stall.
    set_in(0, 0, 0, 0);
    finish_cycle();
    finish_cycle();
    set_in(1, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_en", 64'(inst_sram_en), 64'b0);
    chk("rst_mid_valid", 64'(valid_1), 64'b0);
    chk("rst_mid_out", stage_1_to_2, {inst_sram_rdata, PC_RST});
    finish_cycle();
    set_in(0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_valid", 64'(valid_1), 64'b0);
    chk("post_rst_en", 64'(inst_sram_en), 64'b1);
    chk("post_rst_addr", 64'(inst_sram_addr), 64'(RESET_PC));
    finish_cycle();
    @(negedge clk);
    chk("post_rst_valid1", 64'(valid_1), 64'b1);
    chk("post_rst_pc", 64'(stage_1_to_2[31:0]), 64'(RESET_PC));
    chk("post_rst_inst", 64'(stage_1_to_2[63:32]), 64'(mem(RESET_PC)));
    chk("post_rst_stall", 64'(inst_sram_en), 64'b0);
    finish_cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 3) == 0) ? $urandom() : RESET_PC + {$urandom_range(0, 255), 2'b00};
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 5) == 0, t);
      @(negedge clk);
      check_model();
      finish_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
